ring_router_mux: RTL and testbench

Merges two flit streams onto one outgoing ring link: flits forwarded from the incoming ring, and flits injected by the local endpoint. Arbitration happens only at packet boundaries, so a multi-flit packet (worm) is never interleaved with another. Fairness is round-robin between the two sources per packet. The block sits on the transmit side of each ring router, opposite the receive-side demux. The output is registered for timing.

---
 rtl/ring_router_mux_if.sv | 33 +++
 rtl/ring_router_mux.sv | 104 ++++++++++
 tb/tb_ring_router_mux.sv | 273 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ring_router_mux_if.sv
// Flit payload type and the handshake bundle joining the ring and local sources to the merged ring link.
package ring_router_mux_pkg;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              valid;
  } dii_flit_t;
endpackage

interface ring_router_mux_if;
  import ring_router_mux_pkg::*;

  dii_flit_t in_ring;
  logic      in_ring_ready;
  dii_flit_t in_local;
  logic      in_local_ready;
  dii_flit_t out_ring;
  logic      out_ring_ready;

  // Upstream sources and downstream sink
  modport master (
    output in_ring, in_local, out_ring_ready,
    input  in_ring_ready, in_local_ready, out_ring
  );

  // The mux itself
  modport slave (
    input  in_ring, in_local, out_ring_ready,
    output in_ring_ready, in_local_ready, out_ring
  );
endinterface

// File: rtl/ring_router_mux.sv
// Transmit-side ring mux: merges ring-forwarded and locally injected worms onto one
// registered output link, arbitrating round-robin only at packet boundaries.
module ring_router_mux
  import ring_router_mux_pkg::*;
#(
  parameter bit LOCAL_FIRST = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  ring_router_mux_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RING  = 2'd1,
    ST_LOCAL = 2'd2
  } state_e;

  state_e    state_q, state_d;
  logic      prio_q, prio_d;   // 0 = ring favoured on the next tie, 1 = local
  dii_flit_t out_q, out_d;

  logic      can_accept_c;
  logic      grant_ring_c, grant_local_c;
  logic      acc_ring_c, acc_local_c, acc_any_c;
  logic      acc_last_c;
  dii_flit_t acc_flit_c;

  // State, priority and output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= LOCAL_FIRST;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      out_q   <= out_d;
    end
  end

  // Next-state, priority and output-register load
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    out_d   = out_q;

    if (can_accept_c) begin
      out_d = acc_any_c ? acc_flit_c : dii_flit_t'('0);
    end

    if (acc_any_c && acc_last_c) begin
      prio_d = acc_ring_c;
    end

    case (state_q)
      ST_IDLE: begin
        if (acc_any_c && !acc_last_c) begin
          state_d = acc_ring_c ? ST_RING : ST_LOCAL;
        end
      end
      ST_RING, ST_LOCAL: begin
        if (acc_any_c && acc_last_c) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant, ready and acceptance decode
  always_comb begin
    grant_ring_c  = 1'b0;
    grant_local_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_ring.valid && !(bus.in_local.valid && prio_q)) begin
          grant_ring_c = 1'b1;
        end else if (bus.in_local.valid) begin
          grant_local_c = 1'b1;
        end
      end
      ST_RING:  grant_ring_c  = bus.in_ring.valid;
      ST_LOCAL: grant_local_c = bus.in_local.valid;
      default: begin
        grant_ring_c  = 1'b0;
        grant_local_c = 1'b0;
      end
    endcase

    can_accept_c = !out_q.valid || bus.out_ring_ready;
    acc_ring_c   = can_accept_c && grant_ring_c && bus.in_ring.valid;
    acc_local_c  = can_accept_c && grant_local_c && bus.in_local.valid;
    acc_any_c    = acc_ring_c || acc_local_c;
    acc_flit_c   = acc_ring_c ? bus.in_ring : bus.in_local;
    acc_last_c   = acc_flit_c.last;
  end

  assign bus.in_ring_ready  = can_accept_c && grant_ring_c;
  assign bus.in_local_ready = can_accept_c && grant_local_c;
  assign bus.out_ring       = out_q;

endmodule

// File: tb/tb_ring_router_mux.sv
// Directed bench for ring_router_mux: reset, single source, tie arbitration,
// round-robin alternation, backpressure and mid-packet reset.
module tb_ring_router_mux;
  import ring_router_mux_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  ring_router_mux_if bus_if ();

  ring_router_mux #(.LOCAL_FIRST(1'b0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  function automatic dii_flit_t mk(input logic [15:0] d, input logic l);
    dii_flit_t f;
    f.data  = d;
    f.last  = l;
    f.valid = 1'b1;
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus_if.in_ring        = '0;
    bus_if.in_local       = '0;
    bus_if.out_ring_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.in_ring        = '0;
    bus_if.in_local       = '0;
    bus_if.out_ring_ready = 1'b0;
    tick();
    n_tests++;
    if (bus_if.in_ring_ready !== 1'b0 || bus_if.in_local_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_during readies got %b/%b want 0/0", bus_if.in_ring_ready, bus_if.in_local_ready);
    end
    tick();
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_tests++;
      if (bus_if.out_ring !== dii_flit_t'('0) || bus_if.in_ring_ready !== 1'b0 ||
          bus_if.in_local_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d out=%h rr=%b lr=%b want out=0 rr=0 lr=0",
                 c, bus_if.out_ring, bus_if.in_ring_ready, bus_if.in_local_ready);
      end
    end
  endtask

  task automatic test_ring_packet();
    logic [15:0] d [3];
    d[0] = 16'h0005; d[1] = 16'hAAAA; d[2] = 16'hBBBB;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      bus_if.in_ring = mk(d[i], (i == 2));
      #1;
      n_tests++;
      if (bus_if.in_ring_ready !== 1'b1 || bus_if.in_local_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL ring_pkt_ready i=%0d got %b/%b want 1/0", i, bus_if.in_ring_ready, bus_if.in_local_ready);
      end
      tick();
      bus_if.in_ring = '0;
      n_tests++;
      if (bus_if.out_ring !== mk(d[i], (i == 2))) begin
        n_fail++;
        $display("FAIL ring_pkt_out i=%0d got %h want %h", i, bus_if.out_ring, mk(d[i], (i == 2)));
      end
    end
    tick();
    n_tests++;
    if (bus_if.out_ring.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ring_pkt_drain valid got %b want 0", bus_if.out_ring.valid);
    end
  endtask

  task automatic test_tie_2flit();
    dii_flit_t rf [2];
    dii_flit_t lf [2];
    dii_flit_t exp_out [4];
    int ri = 0;
    int li = 0;
    rf[0] = mk(16'h0101, 1'b0); rf[1] = mk(16'h0102, 1'b1);
    lf[0] = mk(16'h0201, 1'b0); lf[1] = mk(16'h0202, 1'b1);
    exp_out[0] = rf[0]; exp_out[1] = rf[1]; exp_out[2] = lf[0]; exp_out[3] = lf[1];
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus_if.in_ring  = (ri < 2) ? rf[ri] : dii_flit_t'('0);
      bus_if.in_local = (li < 2) ? lf[li] : dii_flit_t'('0);
      #1;
      n_tests++;
      if (bus_if.in_ring_ready !== (c < 2) || bus_if.in_local_ready !== (c >= 2)) begin
        n_fail++;
        $display("FAIL tie_ready c=%0d got %b/%b want %b/%b", c, bus_if.in_ring_ready,
                 bus_if.in_local_ready, (c < 2), (c >= 2));
      end
      if (c < 2) ri++; else li++;
      tick();
      n_tests++;
      if (bus_if.out_ring !== exp_out[c]) begin
        n_fail++;
        $display("FAIL tie_out c=%0d got %h want %h", c, bus_if.out_ring, exp_out[c]);
      end
    end
    bus_if.in_ring  = '0;
    bus_if.in_local = '0;
  endtask

  task automatic test_alternate();
    dii_flit_t exp_f;
    do_reset();
    bus_if.in_ring  = mk(16'h1111, 1'b1);
    bus_if.in_local = mk(16'h2222, 1'b1);
    for (int c = 0; c < 6; c++) begin
      #1;
      n_tests++;
      if (bus_if.in_ring_ready !== (c % 2 == 0) || bus_if.in_local_ready !== (c % 2 == 1)) begin
        n_fail++;
        $display("FAIL alt_ready c=%0d got %b/%b", c, bus_if.in_ring_ready, bus_if.in_local_ready);
      end
      tick();
      exp_f = (c % 2 == 0) ? mk(16'h1111, 1'b1) : mk(16'h2222, 1'b1);
      n_tests++;
      if (bus_if.out_ring !== exp_f) begin
        n_fail++;
        $display("FAIL alt_out c=%0d got %h want %h", c, bus_if.out_ring, exp_f);
      end
    end
    bus_if.in_ring  = '0;
    bus_if.in_local = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    bus_if.in_ring = mk(16'h3001, 1'b0);
    tick();
    bus_if.in_ring = mk(16'h3002, 1'b0);
    tick();
    n_tests++;
    if (bus_if.out_ring !== mk(16'h3002, 1'b0)) begin
      n_fail++;
      $display("FAIL bp_pre got %h want %h", bus_if.out_ring, mk(16'h3002, 1'b0));
    end
    bus_if.in_ring        = mk(16'h3003, 1'b1);
    bus_if.in_local       = mk(16'h4001, 1'b1);
    bus_if.out_ring_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_tests++;
      if (bus_if.in_ring_ready !== 1'b0 || bus_if.in_local_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_ready c=%0d got %b/%b want 0/0", c, bus_if.in_ring_ready, bus_if.in_local_ready);
      end
      tick();
      n_tests++;
      if (bus_if.out_ring !== mk(16'h3002, 1'b0)) begin
        n_fail++;
        $display("FAIL bp_hold c=%0d got %h want %h", c, bus_if.out_ring, mk(16'h3002, 1'b0));
      end
    end
    bus_if.out_ring_ready = 1'b1;
    #1;
    n_tests++;
    if (bus_if.in_ring_ready !== 1'b1 || bus_if.in_local_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release_ready got %b/%b want 1/0", bus_if.in_ring_ready, bus_if.in_local_ready);
    end
    tick();
    bus_if.in_ring = '0;
    n_tests++;
    if (bus_if.out_ring !== mk(16'h3003, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_last got %h want %h", bus_if.out_ring, mk(16'h3003, 1'b1));
    end
    #1;
    n_tests++;
    if (bus_if.in_local_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_next_local_ready got %b want 1", bus_if.in_local_ready);
    end
    tick();
    bus_if.in_local = '0;
    n_tests++;
    if (bus_if.out_ring !== mk(16'h4001, 1'b1)) begin
      n_fail++;
      $display("FAIL bp_next_local got %h want %h", bus_if.out_ring, mk(16'h4001, 1'b1));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus_if.in_local = mk(16'h5001, 1'b0);
    tick();
    n_tests++;
    if (bus_if.out_ring !== mk(16'h5001, 1'b0)) begin
      n_fail++;
      $display("FAIL mid_first got %h want %h", bus_if.out_ring, mk(16'h5001, 1'b0));
    end
    bus_if.in_local = mk(16'h5002, 1'b0);
    bus_if.in_ring  = mk(16'h6001, 1'b0);
    #1;
    n_tests++;
    if (bus_if.in_ring_ready !== 1'b0 || bus_if.in_local_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_worm_lock got %b/%b want 0/1", bus_if.in_ring_ready, bus_if.in_local_ready);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.in_local = '0;
    #1;
    n_tests++;
    if (bus_if.out_ring.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_valid got %b want 0", bus_if.out_ring.valid);
    end
    n_tests++;
    if (bus_if.in_ring_ready !== 1'b1 || bus_if.in_local_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_regrant got %b/%b want 1/0", bus_if.in_ring_ready, bus_if.in_local_ready);
    end
    tick();
    n_tests++;
    if (bus_if.out_ring !== mk(16'h6001, 1'b0)) begin
      n_fail++;
      $display("FAIL mid_ring0 got %h want %h", bus_if.out_ring, mk(16'h6001, 1'b0));
    end
    bus_if.in_ring = mk(16'h6002, 1'b1);
    tick();
    bus_if.in_ring = '0;
    n_tests++;
    if (bus_if.out_ring !== mk(16'h6002, 1'b1)) begin
      n_fail++;
      $display("FAIL mid_ring1 got %h want %h", bus_if.out_ring, mk(16'h6002, 1'b1));
    end
  endtask

  initial begin
    bus_if.in_ring        = '0;
    bus_if.in_local       = '0;
    bus_if.out_ring_ready = 1'b0;
    test_reset();
    test_ring_packet();
    test_tie_2flit();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
